// File: rtl/pcie_pop_ctrl.sv
// rtl/pcie_pop_ctrl.sv - round-robin pop controller for the two pcie_trans FIFOs with a 2-entry skid buffer
//
// Purpose: pops D0/D1 round-robin while buffer credit allows, captures each popped word one
//          cycle later into a 2-entry skid buffer, and streams it out tagged with its source lane.
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_D0_can_pop, i_D1_can_pop   source FIFOs non-empty
//   i_data_in0, i_data_in1       source words, valid the cycle after the matching pop
//   i_ready_in                   downstream accepts o_data_out while o_valid_out is high
//   o_pop_D0, o_pop_D1           pop requests (combinational)
//   o_data_out, o_lane_out       head word of the skid buffer and its source lane
//   o_valid_out                  skid buffer non-empty
//   o_idle                       idle with nothing in flight and nothing buffered
//   o_cnt_D0, o_cnt_D1           delivered-word counters per lane (wrap)
module pcie_pop_ctrl #(
   parameter int BITNUMBER = 6,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_D0_can_pop,
   input  logic                 i_D1_can_pop,
   input  logic [BITNUMBER-1:0] i_data_in0,
   input  logic [BITNUMBER-1:0] i_data_in1,
   input  logic                 i_ready_in,
   output logic                 o_pop_D0,
   output logic                 o_pop_D1,
   output logic [BITNUMBER-1:0] o_data_out,
   output logic                 o_lane_out,
   output logic                 o_valid_out,
   output logic                 o_idle,
   output logic [CNT_WIDTH-1:0] o_cnt_D0,
   output logic [CNT_WIDTH-1:0] o_cnt_D1
);

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_IDLE   = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               r_state;
   logic [1:0]           r_occ;
   logic                 r_head;
   logic                 r_tail;
   logic [BITNUMBER-1:0] r_mem [2];
   logic                 r_lane_mem [2];
   logic                 r_inflight;
   logic                 r_inflight_lane;
   logic                 r_last_grant;
   logic [CNT_WIDTH-1:0] r_cnt_D0;
   logic [CNT_WIDTH-1:0] r_cnt_D1;

   logic                 w_deq;
   logic                 w_enq;
   logic [2:0]           w_used;
   logic                 w_space_ok;
   logic                 w_pop_en;
   logic                 w_pop_D0;
   logic                 w_pop_D1;
   logic                 w_any_can;
   logic [BITNUMBER-1:0] w_enq_data;

   assign w_deq     = (r_occ != 2'd0) & i_ready_in;
   assign w_enq     = r_inflight;
   assign w_any_can = i_D0_can_pop | i_D1_can_pop;

   // Credit: occupied slots plus the word in flight, minus the slot freed this cycle,
   // must leave at least one slot for the word a new pop will deliver.
   assign w_used     = {1'b0, r_occ} + {2'b00, r_inflight};
   assign w_space_ok = w_used < (3'd2 + {2'b00, w_deq});

   // Pops are legal in IDLE too, so the first word goes out in the cycle can_pop rises.
   assign w_pop_en = ~i_reset & (r_state != S_INIT) & w_space_ok;

   // On a tie the lane that did not win last time gets the grant.
   assign w_pop_D0 = w_pop_en & i_D0_can_pop & (~i_D1_can_pop | r_last_grant);
   assign w_pop_D1 = w_pop_en & i_D1_can_pop & (~i_D0_can_pop | ~r_last_grant);

   assign w_enq_data = r_inflight_lane ? i_data_in1 : i_data_in0;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= S_INIT;
         r_occ           <= 2'd0;
         r_head          <= 1'b0;
         r_tail          <= 1'b0;
         r_mem[0]        <= '0;
         r_mem[1]        <= '0;
         r_lane_mem[0]   <= 1'b0;
         r_lane_mem[1]   <= 1'b0;
         r_inflight      <= 1'b0;
         r_inflight_lane <= 1'b0;
         r_last_grant    <= 1'b1;
         r_cnt_D0        <= '0;
         r_cnt_D1        <= '0;
      end else begin
         case (r_state)
            S_INIT:   r_state <= S_IDLE;
            S_IDLE:   if (w_any_can) r_state <= S_ACTIVE;
            S_ACTIVE: if (!w_any_can && !r_inflight && r_occ == 2'd0) r_state <= S_IDLE;
            default:  r_state <= S_INIT;
         endcase

         r_inflight      <= w_pop_D0 | w_pop_D1;
         r_inflight_lane <= w_pop_D1;
         if (w_pop_D0 | w_pop_D1) r_last_grant <= w_pop_D1;

         if (w_enq) begin
            r_mem[r_tail]      <= w_enq_data;
            r_lane_mem[r_tail] <= r_inflight_lane;
            r_tail             <= ~r_tail;
         end

         if (w_deq) begin
            r_head <= ~r_head;
            if (r_lane_mem[r_head]) r_cnt_D1 <= r_cnt_D1 + CNT_ONE;
            else                    r_cnt_D0 <= r_cnt_D0 + CNT_ONE;
         end

         r_occ <= r_occ + {1'b0, w_enq} - {1'b0, w_deq};
      end
   end

   assign o_pop_D0    = w_pop_D0;
   assign o_pop_D1    = w_pop_D1;
   assign o_data_out  = r_mem[r_head];
   assign o_lane_out  = r_lane_mem[r_head];
   assign o_valid_out = (r_occ != 2'd0);
   assign o_idle      = (r_state == S_IDLE) & ~r_inflight & (r_occ == 2'd0);
   assign o_cnt_D0    = r_cnt_D0;
   assign o_cnt_D1    = r_cnt_D1;

endmodule

// File: tb/tb_pcie_pop_ctrl.sv
// tb/tb_pcie_pop_ctrl.sv - self-checking bench for pcie_pop_ctrl
module tb_pcie_pop_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       c0 = 1'b0;
   logic       c1 = 1'b0;
   logic       ready = 1'b0;
   logic [5:0] d0 = '0;
   logic [5:0] d1 = '0;

   logic       a_pop0, a_pop1, a_lane, a_valid, a_idle;
   logic [5:0] a_data;
   logic [7:0] a_cnt0, a_cnt1;
   logic       b_pop0, b_pop1, b_lane, b_valid, b_idle;
   logic [5:0] b_data;
   logic [1:0] b_cnt0, b_cnt1;

   always #5 clk = ~clk;

   pcie_pop_ctrl #(.BITNUMBER(6), .CNT_WIDTH(8)) u_dut (
      .i_clk(clk), .i_reset(reset), .i_D0_can_pop(c0), .i_D1_can_pop(c1),
      .i_data_in0(d0), .i_data_in1(d1), .i_ready_in(ready),
      .o_pop_D0(a_pop0), .o_pop_D1(a_pop1), .o_data_out(a_data), .o_lane_out(a_lane),
      .o_valid_out(a_valid), .o_idle(a_idle), .o_cnt_D0(a_cnt0), .o_cnt_D1(a_cnt1));

   pcie_pop_ctrl #(.BITNUMBER(6), .CNT_WIDTH(2)) u_dut_w2 (
      .i_clk(clk), .i_reset(reset), .i_D0_can_pop(c0), .i_D1_can_pop(c1),
      .i_data_in0(d0), .i_data_in1(d1), .i_ready_in(ready),
      .o_pop_D0(b_pop0), .o_pop_D1(b_pop1), .o_data_out(b_data), .o_lane_out(b_lane),
      .o_valid_out(b_valid), .o_idle(b_idle), .o_cnt_D0(b_cnt0), .o_cnt_D1(b_cnt1));

   typedef struct {
      int w;
      int l;
   } ent_t;

   int   n_vec = 0;
   int   n_err = 0;
   int   fifo0[$];
   int   fifo1[$];
   ent_t mbuf[$];
   ent_t infl;
   bit   infl_v = 0;
   bit   m_init = 1;
   bit   m_active = 0;
   bit   m_last = 1;
   int   m_cnt0 = 0;
   int   m_cnt1 = 0;
   int   dut_pops = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, check against the model, advance the model.
   task automatic do_cycle(input bit rst, input bit rdy);
      bit   exp_valid, deq, any, ep0, ep1, nxt_active;
      int   outn;
      ent_t e;
      @(negedge clk);
      reset = rst;
      ready = rdy;
      c0 = (fifo0.size() > 0);
      c1 = (fifo1.size() > 0);
      d0 = (infl_v && infl.l == 0) ? 6'(infl.w) : 6'($urandom_range(0, 63));
      d1 = (infl_v && infl.l == 1) ? 6'(infl.w) : 6'($urandom_range(0, 63));
      #1;
      dut_pops += int'(a_pop0) + int'(a_pop1);
      if (rst) begin
         check_val("rst_pop0", {31'd0, a_pop0}, 32'd0);
         check_val("rst_pop1", {31'd0, a_pop1}, 32'd0);
         fifo0.delete();
         fifo1.delete();
         mbuf.delete();
         infl_v = 0;
         m_init = 1;
         m_active = 0;
         m_last = 1;
         m_cnt0 = 0;
         m_cnt1 = 0;
         return;
      end

      exp_valid = (mbuf.size() > 0);
      check_val("valid_out", {31'd0, a_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
         check_val("data_out", {26'd0, a_data}, 32'(mbuf[0].w));
         check_val("lane_out", {31'd0, a_lane}, 32'(mbuf[0].l));
      end
      deq  = exp_valid && rdy;
      outn = mbuf.size() + int'(infl_v);
      any  = c0 | c1;
      ep0  = 0;
      ep1  = 0;
      if (!m_init && any && (outn - int'(deq)) < 2) begin
         if (c0 && c1) begin
            if (m_last) ep0 = 1; else ep1 = 1;
         end else if (c0) ep0 = 1;
         else ep1 = 1;
      end
      check_val("pop_D0", {31'd0, a_pop0}, {31'd0, ep0});
      check_val("pop_D1", {31'd0, a_pop1}, {31'd0, ep1});
      check_val("idle", {31'd0, a_idle},
                {31'd0, (!m_init && !m_active && !infl_v && mbuf.size() == 0)});
      check_val("cnt_D0", {24'd0, a_cnt0}, 32'(m_cnt0 % 256));
      check_val("cnt_D1", {24'd0, a_cnt1}, 32'(m_cnt1 % 256));
      check_val("cnt_D1_w2", {30'd0, b_cnt1}, 32'(m_cnt1 % 4));

      if (m_init) nxt_active = 0;
      else if (!m_active) nxt_active = any;
      else nxt_active = any || infl_v || (mbuf.size() > 0);

      if (deq) begin
         e = mbuf.pop_front();
         if (e.l == 0) m_cnt0++; else m_cnt1++;
      end
      if (infl_v) mbuf.push_back(infl);
      infl_v = ep0 | ep1;
      if (ep0) begin
         infl.w = fifo0.pop_front();
         infl.l = 0;
         m_last = 0;
      end else if (ep1) begin
         infl.w = fifo1.pop_front();
         infl.l = 1;
         m_last = 1;
      end
      m_active = nxt_active;
      m_init = 0;
   endtask

   task automatic do_reset();
      do_cycle(1, 0);
      do_cycle(1, 0);
   endtask

   initial begin
      // 1: reset then idle
      do_reset();
      for (int i = 0; i < 10; i++) do_cycle(0, $urandom_range(0, 1) == 1);
      check_val("t1_idle", {31'd0, a_idle}, 32'd1);
      check_val("t1_data_zero", {26'd0, a_data}, 32'd0);
      check_val("t1_lane_zero", {31'd0, a_lane}, 32'd0);

      // 2: single lane stream
      do_reset();
      do_cycle(0, 1);
      for (int i = 1; i <= 4; i++) fifo0.push_back(i);
      dut_pops = 0;
      for (int i = 0; i < 10; i++) do_cycle(0, 1);
      check_val("t2_pops", 32'(dut_pops), 32'd4);
      check_val("t2_cnt0", {24'd0, a_cnt0}, 32'd4);

      // 3: round-robin over both lanes
      do_reset();
      do_cycle(0, 1);
      for (int i = 0; i < 3; i++) begin
         fifo0.push_back(6'h10 + i);
         fifo1.push_back(6'h20 + i);
      end
      for (int i = 0; i < 12; i++) do_cycle(0, 1);
      check_val("t3_cnt0", {24'd0, a_cnt0}, 32'd3);
      check_val("t3_cnt1", {24'd0, a_cnt1}, 32'd3);

      // 4: backpressure, exactly two pops, then drain
      do_reset();
      do_cycle(0, 0);
      for (int i = 0; i < 6; i++) fifo0.push_back(6'h30 + i);
      dut_pops = 0;
      for (int i = 0; i < 8; i++) do_cycle(0, 0);
      check_val("t4_pops_held", 32'(dut_pops), 32'd2);
      check_val("t4_valid_held", {31'd0, a_valid}, 32'd1);
      check_val("t4_data_held", {26'd0, a_data}, 32'h30);
      for (int i = 0; i < 14; i++) do_cycle(0, 1);
      check_val("t4_cnt0", {24'd0, a_cnt0}, 32'd6);

      // 5: reset with occ=1 and a word in flight
      do_reset();
      do_cycle(0, 0);
      for (int i = 0; i < 4; i++) fifo0.push_back(6'h08 + i);
      do_cycle(0, 0);
      do_cycle(0, 0);
      do_cycle(1, 0);
      do_cycle(0, 1);
      check_val("t5_valid", {31'd0, a_valid}, 32'd0);
      check_val("t5_cnt0", {24'd0, a_cnt0}, 32'd0);
      for (int i = 0; i < 6; i++) do_cycle(0, 1);
      check_val("t5_cnt0_after", {24'd0, a_cnt0}, 32'd0);

      // 6: counter wrap on the narrow-counter instance
      do_reset();
      do_cycle(0, 1);
      for (int i = 0; i < 5; i++) fifo1.push_back(6'h3A + i);
      for (int i = 0; i < 12; i++) do_cycle(0, 1);
      check_val("t6_cnt1_w2", {30'd0, b_cnt1}, 32'd1);
      check_val("t6_cnt1", {24'd0, a_cnt1}, 32'd5);

      // Randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0 && fifo0.size() < 8) fifo0.push_back($urandom_range(0, 63));
         if ($urandom_range(0, 2) == 0 && fifo1.size() < 8) fifo1.push_back($urandom_range(0, 63));
         do_cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
